// File: rtl/division_pkg.sv
// Shared types and sizing for the DIV/CMP functional unit.
package division_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = $clog2(DATA_W) + 1;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/division_unit_if.sv
// Request/result bundle between the execute stage (master) and the divider (slave).
interface division_unit_if;
    import division_pkg::*;

    logic  start;
    data_t rs1;
    data_t rs2;
    logic  busy;
    logic  done;
    data_t quotient;
    data_t remainder;
    logic  div_by_zero;
    data_t greater;
    data_t equal;
    data_t less;

    modport master (
        output start, rs1, rs2,
        input  busy, done, quotient, remainder, div_by_zero, greater, equal, less
    );

    modport slave (
        input  start, rs1, rs2,
        output busy, done, quotient, remainder, div_by_zero, greater, equal, less
    );

endinterface

// File: rtl/division_cmp.sv
// Unsigned magnitude comparator producing one-hot greater/equal/less.
module division_cmp
    import division_pkg::*;
(
    input  data_t a,
    input  data_t b,
    output logic  gt,
    output logic  eq,
    output logic  lt
);

    always_comb begin
        gt = (a > b);
        eq = (a == b);
        lt = (a < b);
    end

endmodule

// File: rtl/division_unit.sv
// Multi-cycle 16-bit unsigned restoring divider with registered compare flags.
module division_unit
    import division_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    division_unit_if.slave  bus
);

    state_e state_q;
    cnt_t   cnt_q;
    data_t  dividend_q;
    data_t  divisor_q;
    data_t  rem_q;
    data_t  quo_q;
    logic   busy_q;
    logic   done_q;
    data_t  quotient_q;
    data_t  remainder_q;
    logic   dbz_q;
    logic   gt_q;
    logic   eq_q;
    logic   lt_q;

    logic [DATA_W:0] partial;
    logic            fits;
    data_t           rem_d;
    data_t           quo_d;
    logic            cmp_gt;
    logic            cmp_eq;
    logic            cmp_lt;
    logic            accept;

    // Compares the operands being latched so the flags land on the capture edge.
    division_cmp u_cmp (
        .a  (bus.rs1),
        .b  (bus.rs2),
        .gt (cmp_gt),
        .eq (cmp_eq),
        .lt (cmp_lt)
    );

    always_comb begin
        partial = {rem_q, quo_q[DATA_W-1]};
        fits    = (partial >= {1'b0, divisor_q});
        // Remainder stays below the divisor, so the low bits of the difference suffice.
        rem_d   = fits ? (partial[DATA_W-1:0] - divisor_q) : partial[DATA_W-1:0];
        quo_d   = {quo_q[DATA_W-2:0], fits};
        accept  = bus.start && ((state_q == IDLE) || (state_q == DONE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            gt_q        <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        state_q    <= RUN;
                        cnt_q      <= '0;
                        dividend_q <= bus.rs1;
                        divisor_q  <= bus.rs2;
                        quo_q      <= bus.rs1;
                        rem_q      <= '0;
                        busy_q     <= 1'b1;
                        dbz_q      <= (bus.rs2 == '0);
                        gt_q       <= cmp_gt;
                        eq_q       <= cmp_eq;
                        lt_q       <= cmp_lt;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + cnt_t'(1);
                    if (cnt_q == cnt_t'(DATA_W - 1)) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= dbz_q ? '1 : quo_d;
                        remainder_q <= dbz_q ? dividend_q : rem_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.greater     = data_t'(gt_q);
    assign bus.equal       = data_t'(eq_q);
    assign bus.less        = data_t'(lt_q);

endmodule

// File: tb/tb_division_unit.sv
// Directed self-checking bench for division_unit with hand-computed expectations.
module tb_division_unit;
    import division_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cycles;
    int unsigned pulses;

    always #5 clk = ~clk;

    division_unit_if bus ();

    division_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] q, input logic [31:0] r,
                             input logic [31:0] dbz, input logic [31:0] g,
                             input logic [31:0] e, input logic [31:0] l);
        check({tag, "_quotient"},  bus.quotient,    q);
        check({tag, "_remainder"}, bus.remainder,   r);
        check({tag, "_dbz"},       bus.div_by_zero, dbz);
        check({tag, "_greater"},   bus.greater,     g);
        check({tag, "_equal"},     bus.equal,       e);
        check({tag, "_less"},      bus.less,        l);
    endtask

    task automatic issue(input string tag, input data_t a, input data_t b);
        bus.rs1   = a;
        bus.rs2   = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, "_busy_at_capture"}, bus.busy, 1);
    endtask

    task automatic wait_done(input string tag);
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check({tag, "_latency"},  cycles,   16);
        check({tag, "_busy_low"}, bus.busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.rs1   = '0;
        bus.rs2   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check_all("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 12 / 2
        issue("d12_2", 16'd12, 16'd2);
        wait_done("d12_2");
        check_all("d12_2", 6, 0, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        check("d12_2_done_pulse_len", bus.done, 0);
        check("d12_2_hold_quotient", bus.quotient, 6);

        // 7 / 7: flags land on capture, results hold while busy
        issue("d7_7", 16'd7, 16'd7);
        check("d7_7_equal_at_capture", bus.equal, 1);
        check("d7_7_quotient_held", bus.quotient, 6);
        wait_done("d7_7");
        check_all("d7_7", 1, 0, 0, 0, 1, 0);
        @(posedge clk);
        #1;

        // 3 / 10
        issue("d3_10", 16'd3, 16'd10);
        wait_done("d3_10");
        check_all("d3_10", 0, 3, 0, 0, 0, 1);
        @(posedge clk);
        #1;

        // 100 / 0, then back-to-back 65535 / 1 from DONE
        issue("d100_0", 16'd100, 16'd0);
        wait_done("d100_0");
        check_all("d100_0", 16'hFFFF, 100, 1, 1, 0, 0);
        issue("d65535_1", 16'hFFFF, 16'd1);
        check("d65535_1_dbz_cleared", bus.div_by_zero, 0);
        check("d65535_1_quotient_held", bus.quotient, 16'hFFFF);
        wait_done("d65535_1");
        check_all("d65535_1", 65535, 0, 0, 1, 0, 0);
        @(posedge clk);
        #1;

        // 50000 / 7 with a stray start at cycle 5
        issue("d50000_7", 16'd50000, 16'd7);
        repeat (4) @(posedge clk);
        #1;
        bus.rs1   = 16'd12;
        bus.rs2   = 16'd2;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("d50000_7_still_busy", bus.busy, 1);
        check("d50000_7_flags_kept", bus.greater, 1);
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) pulses++;
        end
        check("d50000_7_done_pulses", pulses, 1);
        check_all("d50000_7", 7142, 6, 0, 1, 0, 0);

        // reset at cycle 8 of a 200 / 3 run
        issue("abort", 16'd200, 16'd3);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check_all("abort", 0, 0, 0, 0, 0, 0);
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) pulses++;
        end
        check("abort_no_done", pulses, 0);

        issue("fresh12_2", 16'd12, 16'd2);
        wait_done("fresh12_2");
        check_all("fresh12_2", 6, 0, 0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
